irq_controller: RTL and testbench

//  Machine-level interrupt source and arbiter feeding the trap handler's irq_en/irq_code/irq_val.

---
 rtl/irq_controller.sv | 184 ++++++++++++++++++
 tb/tb_irq_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Machine-level interrupt source/arbiter: CLINT-style mtime/mtimecmp/msip, pending view, fixed-priority request FSM.
// Optional macro IRQ_EXT_SYNC_EN: route ext_irq through a 2-flop synchronizer before the MEIP register.
module irq_controller #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic [63:0] mie,
  input  logic [63:0] mstatus_current,
  input  logic [1:0]  priv_lvl,
  input  logic        trap_taken,
  input  logic        trap_done,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [1:0]  bus_addr,
  input  logic [63:0] bus_wdata,
  output logic [63:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        irq_en,
  output logic [3:0]  irq_code,
  output logic [63:0] irq_val,
  output logic [63:0] mip_out
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ADDR_MTIME    = 2'd0;
  localparam logic [1:0] ADDR_MTIMECMP = 2'd1;
  localparam logic [1:0] ADDR_MSIP     = 2'd2;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RET
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          meip_q, mtip_q, msip_pend_q;
  logic          irq_en_q, irq_en_d;
  logic [3:0]    irq_code_q, irq_code_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          rvalid_q;

  logic          tick;
  logic          ext_s;
  logic          ge;
  logic          cand_mei, cand_msi, cand_mti, has_cand;
  logic [3:0]    win_code;

`ifdef IRQ_EXT_SYNC_EN
  logic [1:0] ext_sync_q;

  always_ff @(posedge clk) begin
    if (rst) ext_sync_q <= 2'b00;
    else     ext_sync_q <= {ext_sync_q[0], ext_irq};
  end

  assign ext_s = ext_sync_q[1];
`else
  assign ext_s = ext_irq;
`endif

  // Timer and register-port next state; a bus write to mtime overrides that cycle's increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    presc_d    = presc_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;

    tick    = (presc_q == CW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + CW'(1);
    if (tick) mtime_d = mtime_q + 64'd1;

    if (bus_we) begin
      unique case (bus_addr)
        ADDR_MTIME:    mtime_d    = bus_wdata;
        ADDR_MTIMECMP: mtimecmp_d = bus_wdata;
        ADDR_MSIP:     msip_d     = bus_wdata[0];
        default:       ;
      endcase
    end

    // Reads sample the registers before this cycle's write lands.
    if (bus_re) begin
      unique case (bus_addr)
        ADDR_MTIME:    rdata_d = mtime_q;
        ADDR_MTIMECMP: rdata_d = mtimecmp_q;
        ADDR_MSIP:     rdata_d = {63'd0, msip_q};
        default:       rdata_d = 64'd0;
      endcase
    end
  end

  assign ge       = mstatus_current[3] | (priv_lvl != 2'b11);
  assign cand_mei = meip_q      & mie[11];
  assign cand_msi = msip_pend_q & mie[3];
  assign cand_mti = mtip_q      & mie[7];
  assign has_cand = ge & (cand_mei | cand_msi | cand_mti);
  assign win_code = cand_mei ? CODE_MEI : (cand_msi ? CODE_MSI : CODE_MTI);

  always_comb begin
    state_d    = state_q;
    irq_en_d   = 1'b0;
    irq_code_d = irq_code_q;
    unique case (state_q)
      IDLE: begin
        if (has_cand) begin
          state_d    = REQ;
          irq_en_d   = 1'b1;
          irq_code_d = win_code;
        end
      end
      REQ: begin
        // Acknowledge beats a candidate that vanished in the same cycle.
        if (trap_taken) begin
          state_d = WAIT_RET;
        end else if (!has_cand) begin
          state_d = IDLE;
        end else begin
          irq_en_d   = 1'b1;
          irq_code_d = win_code;
        end
      end
      WAIT_RET: begin
        if (trap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      meip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      msip_pend_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_code_q  <= 4'd0;
      rdata_q     <= 64'd0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      meip_q      <= ext_s;
      mtip_q      <= (mtime_q >= mtimecmp_q);
      msip_pend_q <= msip_q;
      irq_en_q    <= irq_en_d;
      irq_code_q  <= irq_code_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= bus_re;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq_en     = irq_en_q;
  assign irq_code   = irq_code_q;
  assign irq_val    = 64'd0;
  assign mip_out    = {52'd0, meip_q, 3'd0, mtip_q, 3'd0, msip_pend_q, 3'd0};

  logic unused_inputs;
  assign unused_inputs = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0],
                           mstatus_current[63:4], mstatus_current[2:0]};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: table-driven masking/priority vectors, read scoreboard,
// and hand-written sequences for timer, handshake, wrap, ext_irq latency and reset corners.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq;
  logic [63:0] mie;
  logic [63:0] mstatus_current;
  logic [1:0]  priv_lvl;
  logic        trap_taken;
  logic        trap_done;
  logic        bus_we;
  logic        bus_re;
  logic [1:0]  bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq_en;
  logic [3:0]  irq_code;
  logic [63:0] irq_val;
  logic [63:0] mip_out;

  irq_controller #(.PRESCALE(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .ext_irq         (ext_irq),
    .mie             (mie),
    .mstatus_current (mstatus_current),
    .priv_lvl        (priv_lvl),
    .trap_taken      (trap_taken),
    .trap_done       (trap_done),
    .bus_we          (bus_we),
    .bus_re          (bus_re),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_rvalid      (bus_rvalid),
    .irq_en          (irq_en),
    .irq_code        (irq_code),
    .irq_val         (irq_val),
    .mip_out         (mip_out)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef IRQ_EXT_SYNC_EN
  localparam int EXT_LAT = 4;
`else
  localparam int EXT_LAT = 2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read scoreboard: every bus_read pushes its expected data, popped when the DUT pulses bus_rvalid.
  always @(negedge clk) begin
    if (bus_rvalid === 1'b1) begin
      if (rd_q.size() == 0) check("rvalid_unexpected", {63'd0, bus_rvalid}, 64'd0);
      else                  check("bus_rdata", bus_rdata, rd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [63:0] data);
    bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    cyc(1);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [63:0] exp);
    bus_re = 1'b1; bus_addr = addr;
    rd_q.push_back(exp);
    cyc(1);
    bus_re = 1'b0;
  endtask

  task automatic pulse_taken();
    trap_taken = 1'b1; cyc(1); trap_taken = 1'b0;
  endtask

  task automatic pulse_done();
    trap_done = 1'b1; cyc(1); trap_done = 1'b0;
  endtask

  task automatic clear_sources();
    mie = 64'd0; ext_irq = 1'b0;
    bus_write(2'd2, 64'd0);
    bus_write(2'd1, ALL_ONES);
    cyc(3);
  endtask

  typedef struct {
    logic        ext;
    logic        msip;
    logic        tmr;
    logic [63:0] mie;
    logic        gie;
    logic [1:0]  priv;
    logic        exp_en;
    logic [3:0]  exp_code;
    logic [63:0] exp_mip;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int bad;
    int lat;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 64'h888, 1'b1, 2'b11, 1'b1, 4'd11, 64'h888};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 64'h888, 1'b1, 2'b11, 1'b1, 4'd3,  64'h088};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 64'h888, 1'b1, 2'b11, 1'b1, 4'd7,  64'h080};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h088, 1'b1, 2'b11, 1'b1, 4'd3,  64'h888};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h888, 1'b0, 2'b11, 1'b0, 4'd0,  64'h800};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 64'h888, 1'b0, 2'b00, 1'b1, 4'd11, 64'h800};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 64'h888, 1'b0, 2'b01, 1'b1, 4'd11, 64'h800};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 64'h000, 1'b1, 2'b11, 1'b0, 4'd0,  64'h888};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 64'h888, 1'b1, 2'b11, 1'b0, 4'd0,  64'h000};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 64'h800, 1'b1, 2'b11, 1'b0, 4'd0,  64'h080};

    rst = 1'b1; ext_irq = 1'b0; mie = 64'd0; mstatus_current = 64'd0; priv_lvl = 2'b11;
    trap_taken = 1'b0; trap_done = 1'b0;
    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 2'd0; bus_wdata = 64'd0;

    // Reset state
    cyc(2);
    check("rst_irq_en",   {63'd0, irq_en}, 64'd0);
    check("rst_irq_code", {60'd0, irq_code}, 64'd0);
    check("rst_irq_val",  irq_val, 64'd0);
    check("rst_rdata",    bus_rdata, 64'd0);
    check("rst_rvalid",   {63'd0, bus_rvalid}, 64'd0);
    check("rst_mip",      mip_out, 64'd0);
    rst = 1'b0;
    bus_read(2'd0, 64'd0);
    bus_read(2'd1, ALL_ONES);
    bus_read(2'd2, 64'd0);

    // Masking / priority vectors
    for (int i = 0; i < 10; i++) begin
      mie = 64'd0;
      cyc(2);
      ext_irq = vecs[i].ext;
      bus_write(2'd2, {63'd0, vecs[i].msip});
      bus_write(2'd1, vecs[i].tmr ? 64'd0 : ALL_ONES);
      cyc(3);
      mie = vecs[i].mie;
      mstatus_current = {60'd0, vecs[i].gie, 3'd0};
      priv_lvl = vecs[i].priv;
      cyc(4);
      check($sformatf("vec%0d_en", i), {63'd0, irq_en}, {63'd0, vecs[i].exp_en});
      check($sformatf("vec%0d_mip", i), mip_out, vecs[i].exp_mip);
      check($sformatf("vec%0d_val", i), irq_val, 64'd0);
      if (vecs[i].exp_en) check($sformatf("vec%0d_code", i), {60'd0, irq_code}, {60'd0, vecs[i].exp_code});
    end

    // Timer: mtimecmp=10 raises MTI two cycles after mtime reaches 10
    clear_sources();
    mie = 64'h80; mstatus_current = 64'h8; priv_lvl = 2'b11;
    bus_write(2'd0, 64'd0);
    bus_write(2'd1, 64'd10);
    cyc(10);
    check("timer_early", {63'd0, irq_en}, 64'd0);
    cyc(1);
    check("timer_en",   {63'd0, irq_en}, 64'd1);
    check("timer_code", {60'd0, irq_code}, 64'd7);

    // Handshake: request holds without ack, drops on trap_taken until trap_done
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (irq_en !== 1'b1) bad++;
    end
    check("hold_20", bad, 0);
    pulse_taken();
    check("taken_drop", {63'd0, irq_en}, 64'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (irq_en !== 1'b0) bad++;
    end
    check("wait_ret_low", bad, 0);
    pulse_done();
    check("done_idle", {63'd0, irq_en}, 64'd0);
    cyc(1);
    check("done_rereq", {63'd0, irq_en}, 64'd1);
    bus_write(2'd1, ALL_ONES);
    cyc(2);
    check("withdraw", {63'd0, irq_en}, 64'd0);

    // Priority with held ext_irq, then fall back to MSI, MTI, and back to MEI
    mie = 64'h888; ext_irq = 1'b1;
    bus_write(2'd2, 64'd1);
    bus_write(2'd1, 64'd0);
    cyc(3);
    check("prio_code_mei", {60'd0, irq_code}, 64'd11);
    pulse_taken();
    check("prio_taken", {63'd0, irq_en}, 64'd0);
    pulse_done();
    cyc(1);
    check("prio_again_en",   {63'd0, irq_en}, 64'd1);
    check("prio_again_code", {60'd0, irq_code}, 64'd11);
    pulse_taken();
    ext_irq = 1'b0;
    cyc(3);
    check("prio_wait", {63'd0, irq_en}, 64'd0);
    pulse_done();
    cyc(1);
    check("prio_msi_en",   {63'd0, irq_en}, 64'd1);
    check("prio_msi_code", {60'd0, irq_code}, 64'd3);
    bus_write(2'd2, 64'd0);
    cyc(2);
    check("prio_mti_code", {60'd0, irq_code}, 64'd7);
    ext_irq = 1'b1;
    cyc(2);
    check("prio_upgrade_code", {60'd0, irq_code}, 64'd11);
    check("prio_upgrade_en",   {63'd0, irq_en}, 64'd1);

    // trap_taken beats a candidate withdrawn in the same cycle
    trap_taken = 1'b1; mie = 64'd0;
    cyc(1);
    trap_taken = 1'b0; mie = 64'h888;
    cyc(3);
    check("taken_wins", {63'd0, irq_en}, 64'd0);
    pulse_done();
    cyc(1);
    check("taken_wins_rereq", {63'd0, irq_en}, 64'd1);
    clear_sources();

    // Bus: wrap, write-over-increment, rvalid pulse, msip width, reserved address, read-before-write
    bus_write(2'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc(3);
    bus_read(2'd0, 64'd1);
    check("rvalid_high", {63'd0, bus_rvalid}, 64'd1);
    cyc(1);
    check("rvalid_pulse", {63'd0, bus_rvalid}, 64'd0);
    bus_write(2'd0, 64'h1234);
    bus_read(2'd0, 64'h1234);
    bus_write(2'd1, 64'h55);
    bus_read(2'd1, 64'h55);
    bus_write(2'd2, 64'hFFFF);
    bus_read(2'd2, 64'd1);
    bus_write(2'd3, 64'hDEAD);
    bus_read(2'd3, 64'd0);
    bus_we = 1'b1; bus_re = 1'b1; bus_addr = 2'd1; bus_wdata = 64'h77;
    rd_q.push_back(64'h55);
    cyc(1);
    bus_we = 1'b0; bus_re = 1'b0;
    bus_read(2'd1, 64'h77);
    clear_sources();

    // ext_irq rise to irq_en latency
    mie = 64'h800; mstatus_current = 64'h8; priv_lvl = 2'b11;
    cyc(2);
    check("lat_pre", {63'd0, irq_en}, 64'd0);
    ext_irq = 1'b1;
    lat = 0;
    while (lat < 10) begin
      cyc(1);
      lat++;
      if (irq_en === 1'b1) break;
    end
    check("ext_latency", lat, EXT_LAT);

    // Reset while in REQ
    rst = 1'b1;
    cyc(1);
    check("rst_req_en",   {63'd0, irq_en}, 64'd0);
    check("rst_req_code", {60'd0, irq_code}, 64'd0);
    check("rst_req_mip",  mip_out, 64'd0);
    rst = 1'b0;
    bus_read(2'd0, 64'd0);
    bus_read(2'd1, ALL_ONES);
    bus_read(2'd2, 64'd0);
    ext_irq = 1'b0; mie = 64'd0;

    cyc(3);
    check("scoreboard_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
